// File: rtl/tagged_fifo.sv
// tagged_fifo
//   Buffers tagged words from a producer and demultiplexes them into FLUX
//   independent sub-queues, so several data fluxes can share one channel
//   without head-of-line blocking between them.
//   Word layout on din_i / dout_o is {tag, data}.
//
// Ports
//   clk      in   sole clock, rising edge
//   rst_n    in   synchronous active-low reset
//   write_i  in   write strobe
//   din_i    in   tagged word to store (WIDTH)
//   full_o   out  registered; any sub-queue full (conservative for producer)
//   read_i   in   per-flux pop request, lowest set bit honoured (FLUX)
//   empty_o  out  registered per-flux empty flags (FLUX)
//   dout_o   out  combinational head word of the selected sub-queue (WIDTH)
module tagged_fifo #(
  parameter  int FLUX       = 2,
  parameter  int DATA_WIDTH = 18,
  parameter  int DEPTH      = 4,
  localparam int TAG_WIDTH  = (FLUX > 1) ? $clog2(FLUX) : 1,
  localparam int WIDTH      = DATA_WIDTH + TAG_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             write_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             full_o,
  input  logic [FLUX-1:0]  read_i,
  output logic [FLUX-1:0]  empty_o,
  output logic [WIDTH-1:0] dout_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;  // extra MSB is the wrap bit

  logic [DATA_WIDTH-1:0] mem_q [FLUX][DEPTH];
  logic [PW-1:0]         wr_ptr_q [FLUX];
  logic [PW-1:0]         wr_ptr_d [FLUX];
  logic [PW-1:0]         rd_ptr_q [FLUX];
  logic [PW-1:0]         rd_ptr_d [FLUX];
  logic [FLUX-1:0]       empty_q;
  logic [FLUX-1:0]       empty_d;
  logic                  full_q;
  logic                  full_d;

  logic [TAG_WIDTH-1:0]  wr_tag_s;
  logic                  wr_en_s;
  logic                  rd_hit_s;
  logic [TAG_WIDTH-1:0]  rd_sel_s;
  logic                  rd_en_s;
  logic                  ne_hit_s;
  logic [TAG_WIDTH-1:0]  ne_sel_s;

  // Write acceptance: global full blocks all fluxes; out-of-range tags drop.
  always_comb begin
    wr_tag_s = din_i[WIDTH-1:DATA_WIDTH];
    wr_en_s  = write_i && !full_q && (int'(wr_tag_s) < FLUX);
  end

  // Priority selects: lowest set read bit, and lowest non-empty queue.
  always_comb begin
    rd_hit_s = 1'b0;
    rd_sel_s = '0;
    ne_hit_s = 1'b0;
    ne_sel_s = '0;
    for (int i = 0; i < FLUX; i++) begin
      if (read_i[i] && !rd_hit_s) begin
        rd_hit_s = 1'b1;
        rd_sel_s = TAG_WIDTH'(i);
      end else begin
        rd_hit_s = rd_hit_s;
      end
      if (!empty_q[i] && !ne_hit_s) begin
        ne_hit_s = 1'b1;
        ne_sel_s = TAG_WIDTH'(i);
      end else begin
        ne_hit_s = ne_hit_s;
      end
    end
    // A read aimed at an empty queue is dropped, even if a higher bit is set.
    rd_en_s = rd_hit_s && !empty_q[rd_sel_s];
  end

  // Next-state pointers and the flags derived from them.
  always_comb begin
    full_d = 1'b0;
    for (int i = 0; i < FLUX; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      if (wr_en_s && (wr_tag_s == TAG_WIDTH'(i))) begin
        wr_ptr_d[i] = wr_ptr_q[i] + PW'(1);
      end else begin
        wr_ptr_d[i] = wr_ptr_q[i];
      end
      if (rd_en_s && (rd_sel_s == TAG_WIDTH'(i))) begin
        rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
      end else begin
        rd_ptr_d[i] = rd_ptr_q[i];
      end
      empty_d[i] = (wr_ptr_d[i] == rd_ptr_d[i]);
      full_d     = full_d ||
                   ((wr_ptr_d[i][AW-1:0] == rd_ptr_d[i][AW-1:0]) &&
                    (wr_ptr_d[i][AW] != rd_ptr_d[i][AW]));
    end
  end

  // Pointer and flag registers; reset discards all buffered words.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FLUX; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
      empty_q <= {FLUX{1'b1}};
      full_q  <= 1'b0;
    end else begin
      for (int i = 0; i < FLUX; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
      end
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  // Storage array; contents are intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en_s) begin
      mem_q[wr_tag_s][wr_ptr_q[wr_tag_s][AW-1:0]] <= din_i[DATA_WIDTH-1:0];
    end
  end

  // Head-word mux: requested queue first, else lowest non-empty, else zero.
  always_comb begin
    if (rd_hit_s) begin
      dout_o = {rd_sel_s, mem_q[rd_sel_s][rd_ptr_q[rd_sel_s][AW-1:0]]};
    end else if (ne_hit_s) begin
      dout_o = {ne_sel_s, mem_q[ne_sel_s][rd_ptr_q[ne_sel_s][AW-1:0]]};
    end else begin
      dout_o = '0;
    end
  end

  assign empty_o = empty_q;
  assign full_o  = full_q;

endmodule
